axi_write_resp: RTL
===================

Name: axi_write_resp

Overview:
- Write-response stage of the AXI4-Lite slave, sitting downstream of the AW and W channel stages.
- Pairs the captured write address with the captured write data and strobe, and decodes the address.
- Issues a single strobed write to the register memory, then returns BRESP to the master over the B handshake.
- Once the master accepts the response, pulses BRESPREADY/BRESPOUT back to the W channel stage so it can leave DONE.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
MEM_DEPTH, 1024, number of DATA_WIDTH words in the target memory
BASE_ADDR, 0, byte address of word 0

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ADDRIN  input  ADDR_WIDTH  captured write address from AW stage
ADDRREADY  input  1  AW stage: address valid
WDATAIN  input  DATA_WIDTH  data from W stage
WSTRBIN  input  STRB_WIDTH  strobe from W stage
DATAREADY  input  1  W stage: data valid
MEMWEN  output  1  memory write enable, one-cycle pulse
MEMADDR  output  clog2(MEM_DEPTH)  word index
MEMWDATA  output  DATA_WIDTH  write data
MEMWSTRB  output  STRB_WIDTH  byte enables
MEMERR  input  1  memory error, sampled in WRITE
BVALID  output  1  response valid to master
BRESP  output  2  response to master
BREADY  input  1  master ready for response
BRESPREADY  output  1  one-cycle pulse to W stage: response accepted
BRESPOUT  output  2  response value, valid with BRESPREADY

Behaviour:
- Reset: every output is 0, state is IDLE, and both capture flags are clear. A reset mid-transaction aborts it and drops BVALID on the next edge.
- Encodings: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11. 2'b01 is never produced.
- State IDLE:
  - ADDRREADY=1 sets addrFlag and latches ADDRIN.
  - DATAREADY=1 sets dataFlag and latches WDATAIN/WSTRBIN.
  - Arrival order is arbitrary, and both may arrive in the same cycle.
  - A repeat pulse while a flag is already set re-latches that field (the last value wins).
  - When both flags are set (including the cycle the second one arrives), go to WRITE on the next edge.
- State WRITE (exactly 1 cycle), with off = addr - BASE_ADDR:
  - addr < BASE_ADDR, or off>>log2(STRB_WIDTH) >= MEM_DEPTH: resp=DECERR, MEMWEN=0.
  - Else if off[log2(STRB_WIDTH)-1:0] != 0 (misaligned): resp=SLVERR, MEMWEN=0.
  - Else if the latched strobe == 0: resp=OKAY, MEMWEN=0.
  - Else: MEMWEN=1 and MEMADDR/MEMWDATA/MEMWSTRB are driven; resp = MEMERR ? SLVERR : OKAY.
  - The next state is always RESP.
- State RESP:
  - BVALID=1 and BRESP=resp, both held stable until BVALID&&BREADY.
  - BREADY high the same cycle BVALID first rises completes the handshake in that cycle.
  - On the handshake: the next edge drives BVALID=0, BRESPREADY=1 for one cycle, BRESPOUT=resp, clears both flags, and returns to IDLE.
- Outside IDLE, ADDRREADY/DATAREADY are ignored.
- Latency:
  - Last-of-address/data to MEMWEN: 2 cycles.
  - To BVALID: 2 cycles.
  - Handshake to BRESPREADY: 1 cycle.
  - Minimum transaction time is 4 cycles.
- All outputs are registered. MEM* outputs are 0 whenever MEMWEN=0.

Decomposition:
- Shared package axi_lite_pkg holds:
  - the BRESP encodings RESP_OKAY/RESP_EXOKAY/RESP_SLVERR/RESP_DECERR;
  - the state encodings for this block (S_IDLE, S_WRITE, S_RESP);
  - a clog2 function.
- One sub-module is natural: axi_addr_decode. It is purely combinational, maps addr to {index, hit, aligned}, and is reused by the future read-response stage.

Test Plan:
- ADDRIN=0x10 with ADDRREADY, then 3 cycles later WDATAIN=0xDEADBEEF, WSTRBIN=4'hF with DATAREADY, BREADY tied 1 -> MEMWEN pulse 2 cycles after DATAREADY with MEMADDR=4, MEMWDATA=0xDEADBEEF; BVALID=1 with BRESP=00 on the same cycle (BVALID/BRESP are registered from the WRITE decode and rise together with MEMWEN); BRESPREADY pulse with BRESPOUT=00 the following cycle.
- DATAREADY and ADDRREADY in the same cycle, addr 0x20, WSTRBIN=4'b0101 -> MEMWEN 2 cycles later, MEMWSTRB=4'b0101, BRESP=00.
- ADDRIN=0x1000 (index 1024 >= MEM_DEPTH) -> MEMWEN stays 0, BRESP=11.
- ADDRIN=0x12 (misaligned) -> MEMWEN stays 0, BRESP=10.
- MEMERR=1 in WRITE -> BRESP=10.
- Hold BREADY=0 for 5 cycles in RESP -> BVALID/BRESP stable for all 5, no BRESPREADY; raise BREADY -> single BRESPREADY pulse, BVALID=0 next cycle.
- Assert reset in RESP -> next edge all outputs 0; the following 2 ADDRREADY/DATAREADY pulses start a fresh transaction.

Source files
------------

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared AXI4-Lite definitions: response codes, the state
//               encodings of the write-response stage and a clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

  // BRESP / RRESP encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write-response stage states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_write_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_write_resp_if
// Description : Bundle of the AW/W stage hand-off, memory write port and
//               B channel signals seen by the write-response stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_write_resp_if import axi_lite_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 1024
);
  localparam int c_idx_w = clog2(MEM_DEPTH);

  logic [ADDR_WIDTH-1:0] ADDRIN;
  logic                  ADDRREADY;
  logic [DATA_WIDTH-1:0] WDATAIN;
  logic [STRB_WIDTH-1:0] WSTRBIN;
  logic                  DATAREADY;
  logic                  MEMWEN;
  logic [c_idx_w-1:0]    MEMADDR;
  logic [DATA_WIDTH-1:0] MEMWDATA;
  logic [STRB_WIDTH-1:0] MEMWSTRB;
  logic                  MEMERR;
  logic                  BVALID;
  logic [1:0]            BRESP;
  logic                  BREADY;
  logic                  BRESPREADY;
  logic [1:0]            BRESPOUT;

  // The write-response stage itself
  modport slave (
    input  ADDRIN, ADDRREADY, WDATAIN, WSTRBIN, DATAREADY, MEMERR, BREADY,
    output MEMWEN, MEMADDR, MEMWDATA, MEMWSTRB, BVALID, BRESP, BRESPREADY, BRESPOUT
  );

  // The surrounding stages, memory and bus master
  modport master (
    output ADDRIN, ADDRREADY, WDATAIN, WSTRBIN, DATAREADY, MEMERR, BREADY,
    input  MEMWEN, MEMADDR, MEMWDATA, MEMWSTRB, BVALID, BRESP, BRESPREADY, BRESPOUT
  );

endinterface
`default_nettype wire

// File: rtl/axi_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : axi_addr_decode
// Description : Combinational byte-address decoder: word index into the
//               register memory, range hit and word alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_addr_decode import axi_lite_pkg::*; #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    STRB_WIDTH  = 4,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    INDEX_WIDTH = clog2(MEM_DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0]  addr,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   hit,
  output logic                   aligned
);
  localparam int                    c_lsb   = clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_depth = ADDR_WIDTH'(MEM_DEPTH);

  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_word;

  assign w_off  = addr - BASE_ADDR;
  assign w_word = w_off >> c_lsb;
  // Below the base the subtraction wraps, so the lower bound is checked on addr
  assign hit    = (addr >= BASE_ADDR) && (w_word < c_depth);
  assign index  = w_word[INDEX_WIDTH-1:0];

  generate
    if (c_lsb > 0) begin : g_align_check
      assign aligned = (w_off[c_lsb-1:0] == '0);
    end else begin : g_byte_wide
      assign aligned = 1'b1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_write_resp.sv
`default_nettype none
// ============================================================================
// Module      : axi_write_resp
// Description : AXI4-Lite write-response stage. Joins the captured address
//               and data, performs one strobed memory write, returns BRESP
//               and signals completion back to the W stage.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_write_resp import axi_lite_pkg::*; #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input wire logic         clk,
  input wire logic         reset,
  axi_write_resp_if.slave  bus
);
  localparam int c_idx_w = clog2(MEM_DEPTH);

  logic [1:0]            r_state;
  logic                  r_addr_flag;
  logic                  r_data_flag;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;

  logic                  r_memwen;
  logic [c_idx_w-1:0]    r_memaddr;
  logic [DATA_WIDTH-1:0] r_memwdata;
  logic [STRB_WIDTH-1:0] r_memwstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_brespready;
  logic [1:0]            r_brespout;

  logic [c_idx_w-1:0]    w_index;
  logic                  w_hit;
  logic                  w_aligned;
  logic                  w_write_en;
  logic [1:0]            w_resp;

  axi_addr_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STRB_WIDTH  (STRB_WIDTH),
    .MEM_DEPTH   (MEM_DEPTH),
    .BASE_ADDR   (BASE_ADDR),
    .INDEX_WIDTH (c_idx_w)
  ) u_decode (
    .addr    (r_addr),
    .index   (w_index),
    .hit     (w_hit),
    .aligned (w_aligned)
  );

  // Response and write-enable decision for the latched transaction
  always_comb begin
    w_write_en = 1'b0;
    w_resp     = RESP_OKAY;
    if (!w_hit) begin
      w_resp = RESP_DECERR;
    end else if (!w_aligned) begin
      w_resp = RESP_SLVERR;
    end else if (r_wstrb == '0) begin
      w_resp = RESP_OKAY;
    end else begin
      w_write_en = 1'b1;
      w_resp     = bus.MEMERR ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Capture, write and response sequencing; all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr_flag  <= 1'b0;
      r_data_flag  <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_memwen     <= 1'b0;
      r_memaddr    <= '0;
      r_memwdata   <= '0;
      r_memwstrb   <= '0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_brespready <= 1'b0;
      r_brespout   <= RESP_OKAY;
    end else begin
      // Memory port and completion pulse default to idle every cycle
      r_memwen     <= 1'b0;
      r_memaddr    <= '0;
      r_memwdata   <= '0;
      r_memwstrb   <= '0;
      r_brespready <= 1'b0;
      r_brespout   <= RESP_OKAY;
      case (r_state)
        S_IDLE: begin
          if (bus.ADDRREADY) begin
            r_addr_flag <= 1'b1;
            r_addr      <= bus.ADDRIN;
          end
          if (bus.DATAREADY) begin
            r_data_flag <= 1'b1;
            r_wdata     <= bus.WDATAIN;
            r_wstrb     <= bus.WSTRBIN;
          end
          if ((r_addr_flag || bus.ADDRREADY) && (r_data_flag || bus.DATAREADY)) begin
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_memwen <= w_write_en;
          if (w_write_en) begin
            r_memaddr  <= w_index;
            r_memwdata <= r_wdata;
            r_memwstrb <= r_wstrb;
          end
          r_bvalid <= 1'b1;
          r_bresp  <= w_resp;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          if (bus.BREADY) begin
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_brespready <= 1'b1;
            r_brespout   <= r_bresp;
            r_addr_flag  <= 1'b0;
            r_data_flag  <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.MEMWEN     = r_memwen;
  assign bus.MEMADDR    = r_memaddr;
  assign bus.MEMWDATA   = r_memwdata;
  assign bus.MEMWSTRB   = r_memwstrb;
  assign bus.BVALID     = r_bvalid;
  assign bus.BRESP      = r_bresp;
  assign bus.BRESPREADY = r_brespready;
  assign bus.BRESPOUT   = r_brespout;

endmodule
`default_nettype wire
